booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier for the multi-cycle MIPS datapath. It serves both MULT (signed) and MULTU (unsigned) through a per-operation mode bit. It uses a start/busy/done handshake so the control FSM can stall on it, and it writes a 2·WIDTH-bit product to the HI/LO result registers.

---
 rtl/booth_mult_seq.sv | 110 +++++++++++
 tb/tb_booth_mult_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier serving MULT/MULTU for the multi-cycle datapath.
// One Booth iteration per clock over WIDTH+1 bits, start/busy/done handshake, product on hi/lo.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST      = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH+1:0] a_r;
    logic [WIDTH+1:0] m_r;
    logic [WIDTH:0]   q_r;
    logic             q1_r;
    logic [CW-1:0]    count_r;

    logic [WIDTH:0]   ext_m_s;
    logic [WIDTH:0]   ext_q_s;
    logic [WIDTH+1:0] sum_s;
    logic [WIDTH+1:0] a_next_s;
    logic [WIDTH:0]   q_next_s;
    logic             q1_next_s;

    // Operand extension and one Booth add/subtract followed by the arithmetic shift.
    always_comb begin
        ext_m_s = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
        ext_q_s = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
        case ({q_r[0], q1_r})
            2'b01:   sum_s = a_r + m_r;
            2'b10:   sum_s = a_r - m_r;
            default: sum_s = a_r;
        endcase
        a_next_s  = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
        q_next_s  = {sum_s[0], q_r[WIDTH:1]};
        q1_next_s = q_r[0];
    end

    // Control FSM and datapath registers; DONE also accepts a new start so back-to-back
    // requests are spaced WIDTH+2 cycles apart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            a_r     <= '0;
            m_r     <= '0;
            q_r     <= '0;
            q1_r    <= 1'b0;
            count_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        a_r     <= '0;
                        m_r     <= {ext_m_s[WIDTH], ext_m_s};
                        q_r     <= ext_q_s;
                        q1_r    <= 1'b0;
                        count_r <= '0;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    a_r     <= a_next_s;
                    q_r     <= q_next_s;
                    q1_r    <= q1_next_s;
                    count_r <= count_r + COUNT_ONE;
                    // Low 2*WIDTH bits of the (WIDTH+1)x(WIDTH+1) product after the last shift.
                    if (count_r == LAST) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        hi      <= {a_next_s[WIDTH-2:0], q_next_s[WIDTH]};
                        lo      <= q_next_s[WIDTH-1:0];
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mult_seq;

    logic        clock;
    logic        reset;
    logic        start, is_signed;
    logic [31:0] multiplicand, multiplier;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic        start8, is_signed8;
    logic [7:0]  multiplicand8, multiplier8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    booth_mult_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(is_signed8),
        .multiplicand(multiplicand8), .multiplier(multiplier8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full WIDTH=32 operation from IDLE, with latency and busy-length checks.
    task automatic op32(input string tag, input logic sgn, input logic [31:0] m, input logic [31:0] q,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int busy_cnt;
        is_signed = sgn; multiplicand = m; multiplier = q; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 40) begin
            step();
            n++;
            if (busy) busy_cnt++;
        end
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        step();
        chk({tag, " done pulse width"}, {63'd0, done}, 64'd0);
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'd34);
        chk({tag, " busy low after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic op8(input string tag, input logic sgn, input logic [7:0] m, input logic [7:0] q,
                       input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int n;
        is_signed8 = sgn; multiplicand8 = m; multiplier8 = q; start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd9);
        chk({tag, " hi"}, {56'd0, hi8}, {56'd0, exp_hi});
        chk({tag, " lo"}, {56'd0, lo8}, {56'd0, exp_lo});
        step();
        chk({tag, " busy low after"}, {63'd0, busy8}, 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        reset = 1'b1;
        start = 1'b0; is_signed = 1'b0; multiplicand = 32'd0; multiplier = 32'd0;
        start8 = 1'b0; is_signed8 = 1'b0; multiplicand8 = 8'd0; multiplier8 = 8'd0;
        step();
        step();
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        chk("reset busy8", {63'd0, busy8}, 64'd0);
        reset = 1'b0;
        step();

        op32("s -3x7", 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        op32("u ffxff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        op32("s ffxff", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        op32("s min*min", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        op32("s min*1", 1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000);
        op32("u min*2", 1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000);

        // Mid-operation start, mode toggling, then a held start for back-to-back.
        is_signed = 1'b1; multiplicand = 32'hFFFFFFFD; multiplier = 32'h00000007; start = 1'b1;
        step();
        start = 1'b0;
        chk("accept busy", {63'd0, busy}, 64'd1);
        repeat (4) step();
        start = 1'b1; multiplicand = 32'd6; multiplier = 32'd7; is_signed = 1'b0;
        step();
        start = 1'b0; is_signed = 1'b1;
        step();
        is_signed = 1'b0; multiplicand = 32'hFFFFFFFF; multiplier = 32'hFFFFFFFF; start = 1'b1;
        n = 6;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("ignore latency", 64'(n), 64'd33);
        chk("ignore hi", {32'd0, hi}, 64'h00000000FFFFFFFF);
        chk("ignore lo", {32'd0, lo}, 64'h00000000FFFFFFEB);
        step();
        chk("reaccept busy", {63'd0, busy}, 64'd1);
        chk("reaccept done low", {63'd0, done}, 64'd0);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("second latency", 64'(n), 64'd33);
        chk("second hi", {32'd0, hi}, 64'h00000000FFFFFFFE);
        chk("second lo", {32'd0, lo}, 64'h0000000000000001);
        step();
        chk("second busy low", {63'd0, busy}, 64'd0);

        // Reset in the middle of RUN.
        is_signed = 1'b1; multiplicand = 32'h80000000; multiplier = 32'h80000000; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        #1;
        chk("midreset busy", {63'd0, busy}, 64'd0);
        chk("midreset done", {63'd0, done}, 64'd0);
        chk("midreset hi", {32'd0, hi}, 64'd0);
        chk("midreset lo", {32'd0, lo}, 64'd0);
        step();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) pulses++;
        end
        chk("no done after reset", 64'(pulses), 64'd0);
        op32("u 6x7", 1'b0, 32'd6, 32'd7, 32'd0, 32'h0000002A);

        op8("w8 s 80xff", 1'b1, 8'h80, 8'hFF, 8'h00, 8'h80);
        op8("w8 u ffxff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        op8("w8 s 7fx80", 1'b1, 8'h7F, 8'h80, 8'hC0, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
